inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the core's immediate extractor: packs opcode, funct, register and 32-bit immediate fields into a 32-bit RV32IF instruction word.
- Also expands the LI pseudo-instruction into LUI/ADDI.
- Sits between the test-program generator / boot-ROM builder and the instruction memory write port.
- Valid/ready in, valid/ready out, one registered output stage.

Parameters:
- SUPPORT_F, 1: 1 = FLW/FSW/FARITH opcodes legal; 0 = flagged as error.
- LI_ELIDE, 1: 1 = drop the zero half of an LI expansion; 0 = always emit two words.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_li  in  1  LI pseudo-op (opcode/funct/rs ignored)
- req_opcode  in  7  opcode; decode on [6:2]
- req_funct3  in  3
- req_funct7  in  7
- req_rd  in  5
- req_rs1  in  5
- req_rs2  in  5
- req_imm  in  32  signed immediate/offset; U-type holds the full value, low 12 bits zero
- inst_valid  out  1  output word present
- inst_ready  in  1  consumer accepts
- inst_out  out  32  encoded instruction
- inst_err  out  1  word has an out-of-range immediate or an illegal opcode; qualified by inst_valid

Behaviour:
- Reset (rst_n=0 at a clk edge): inst_valid=0, inst_out=0, inst_err=0, state=IDLE.
  - req_ready=0 during the reset cycle.
  - Reset overrides a pending second LI word; that word is discarded.
- Output register: holds the word while inst_valid & !inst_ready; inst_out and inst_err stay stable.
- States:
  - IDLE: req_ready = !inst_valid | inst_ready.
  - LI2: req_ready=0 while the second LI word is pending.
- Latency: word appears on inst_valid the cycle after acceptance. Full throughput is one word per cycle with inst_ready held at 1.
- Encoding by opcode[6:2]:
  - 01100 R: funct7|rs2|rs1|f3|rd|op.
  - 00000/11001/00100/00001 I: imm[11:0]|rs1|f3|rd|op. Legal range -2048..2047.
  - 01000/01001 S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op. Legal range -2048..2047.
  - 11000 B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op. Legal: -4096..4094, even.
  - 11011 J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. Legal: ±1 MiB, even.
  - 01101/00101 U: imm[31:12]|rd|op. Legal only if imm[11:0]==0.
  - 10100 FARITH: as R.
- Range violation: word still emitted with the immediate truncated to the field; inst_err=1.
- Opcode errors: unlisted opcode[6:2], opcode[1:0]!=11, or an FP opcode with SUPPORT_F=0 → inst_out=32'h00000013 (NOP), inst_err=1.
- LI expansion:
  - lo = sext(imm[11:0]); hi = (imm + 32'h800) >> 12, 20 bits, wraps modulo 2^32.
  - Word 1: LUI rd,hi. Word 2: ADDI rd,rd,lo.
  - With LI_ELIDE=1:
    - hi==0 → single ADDI rd,x0,lo.
    - lo==0 → single LUI.
    - imm==0 → single ADDI rd,x0,0.
  - Two-word case: IDLE→LI2 on accept. LI2→IDLE when word 2 is loaded, which happens on the cycle word 1 is consumed.
- rd=x0 is encoded normally; no error.
- req_ready is not combinationally dependent on req_valid.

Test Plan:
- ADDI x1,x2,-1 (op 0010011, f3 0, imm 0xFFFFFFFF) → inst_out=0xFFF10093, inst_err=0, one cycle after accept.
- BEQ x1,x2,+8 → 0x00208463. Same request with imm=7 → inst_err=1. With imm=4096 → inst_err=1.
- LI x5,0x12345FFF → two words in order, 0x123462B7 then 0xFFF28293. req_ready=0 in between.
- LI x5,0x00000123 with LI_ELIDE=1 → single word 0x12300293. With LI_ELIDE=0 → 0x000002B7 then 0x12328293.
- Backpressure: hold inst_ready=0 for 5 cycles during an LI → word 1 stable throughout, req_ready=0; word 2 appears the cycle after inst_ready rises.
- Edge cases:
  - rst_n=0 while in LI2 → next cycle inst_valid=0, state IDLE, no second word emitted.
  - Opcode 0x7F → NOP 0x00000013 with inst_err=1.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs opcode/funct/register/immediate fields into an RV32IF
// instruction word, and expands the LI pseudo-op into LUI/ADDI. One
// registered output stage with valid/ready on both sides.
module inst_encoder #(
  parameter int SUPPORT_F = 1,  // 1: FP load/store/arith opcodes are legal
  parameter int LI_ELIDE  = 1   // 1: drop the zero half of an LI expansion
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_li,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic        inst_err
);

  // opcode[6:2] major groups
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FLW    = 5'b00001;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_FSW    = 5'b01001;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_FARITH = 5'b10100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [6:0]  LUI_OPC  = 7'b0110111;
  localparam logic [6:0]  ADDI_OPC = 7'b0010011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD
  } fmt_t;

  typedef enum logic {
    S_IDLE,
    S_LI2
  } state_t;

  state_t      r_state;
  logic        r_valid;
  logic [31:0] r_out;
  logic        r_err;
  logic [31:0] r_pend;    // second LI word, waiting for word 1 to drain

  fmt_t        w_fmt;
  logic        w_is_fp;
  logic        w_i_ok;
  logic        w_b_ok;
  logic        w_j_ok;
  logic        w_u_ok;
  logic [31:0] w_word;
  logic        w_err;

  logic [31:0] w_li_sum;
  logic [19:0] w_li_hi;
  logic [11:0] w_li_lo;
  logic [31:0] w_li_lui;
  logic [31:0] w_li_addi_x0;
  logic [31:0] w_li_addi_rd;
  logic [31:0] w_li_first;
  logic [31:0] w_li_second;
  logic        w_li_two;

  logic [31:0] w_first;
  logic        w_first_err;
  logic        w_accept;

  // Accept only from IDLE when the output slot is free or draining this cycle;
  // never during reset and never looking at req_valid.
  assign req_ready = rst_n && (r_state == S_IDLE) && (!r_valid || inst_ready);
  assign w_accept  = req_valid && req_ready;

  assign inst_valid = r_valid;
  assign inst_out   = r_out;
  assign inst_err   = r_err;

  // Classify the opcode into an encoding format; anything unrecognised is BAD.
  always_comb begin
    w_fmt   = FMT_BAD;
    w_is_fp = 1'b0;
    if (req_opcode[1:0] == 2'b11) begin
      case (req_opcode[6:2])
        OP_REG:    w_fmt = FMT_R;
        OP_FARITH: begin w_fmt = FMT_R; w_is_fp = 1'b1; end
        OP_LOAD,
        OP_JALR,
        OP_IMM:    w_fmt = FMT_I;
        OP_FLW:    begin w_fmt = FMT_I; w_is_fp = 1'b1; end
        OP_STORE:  w_fmt = FMT_S;
        OP_FSW:    begin w_fmt = FMT_S; w_is_fp = 1'b1; end
        OP_BRANCH: w_fmt = FMT_B;
        OP_JAL:    w_fmt = FMT_J;
        OP_LUI,
        OP_AUIPC:  w_fmt = FMT_U;
        default:   w_fmt = FMT_BAD;
      endcase
    end
    if (w_is_fp && (SUPPORT_F == 0)) w_fmt = FMT_BAD;
  end

  // Immediate range checks: the bits above the field must be a pure sign
  // extension, and branch/jump offsets must be even.
  always_comb begin
    w_i_ok = (&req_imm[31:11]) || (~|req_imm[31:11]);
    w_b_ok = ((&req_imm[31:12]) || (~|req_imm[31:12])) && !req_imm[0];
    w_j_ok = ((&req_imm[31:20]) || (~|req_imm[31:20])) && !req_imm[0];
    w_u_ok = ~|req_imm[11:0];
  end

  // Field packing; out-of-range immediates are still packed (truncated) but flagged.
  always_comb begin
    w_word = NOP_WORD;
    w_err  = 1'b0;
    case (w_fmt)
      FMT_R: w_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      FMT_I: begin
        w_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        w_err  = !w_i_ok;
      end
      FMT_S: begin
        w_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
        w_err  = !w_i_ok;
      end
      FMT_B: begin
        w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                  req_imm[4:1], req_imm[11], req_opcode};
        w_err  = !w_b_ok;
      end
      FMT_J: begin
        w_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_opcode};
        w_err  = !w_j_ok;
      end
      FMT_U: begin
        w_word = {req_imm[31:12], req_rd, req_opcode};
        w_err  = !w_u_ok;
      end
      default: begin
        w_word = NOP_WORD;
        w_err  = 1'b1;
      end
    endcase
  end

  // LI split: hi is rounded so that adding the sign-extended lo restores imm.
  always_comb begin
    w_li_sum     = req_imm + 32'h0000_0800;
    w_li_hi      = w_li_sum[31:12];
    w_li_lo      = req_imm[11:0];
    w_li_lui     = {w_li_hi, req_rd, LUI_OPC};
    w_li_addi_x0 = {w_li_lo, 5'd0, 3'b000, req_rd, ADDI_OPC};
    w_li_addi_rd = {w_li_lo, req_rd, 3'b000, req_rd, ADDI_OPC};
    w_li_first   = w_li_lui;
    w_li_second  = w_li_addi_rd;
    w_li_two     = 1'b1;
    if (LI_ELIDE != 0) begin
      if (w_li_hi == 20'd0) begin
        // also covers imm == 0
        w_li_first = w_li_addi_x0;
        w_li_two   = 1'b0;
      end else if (w_li_lo == 12'd0) begin
        w_li_first = w_li_lui;
        w_li_two   = 1'b0;
      end
    end
  end

  // Select what goes into the output register on acceptance.
  always_comb begin
    w_first     = req_li ? w_li_first : w_word;
    w_first_err = req_li ? 1'b0       : w_err;
  end

  // Output stage and LI sequencing FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_out   <= 32'd0;
      r_err   <= 1'b0;
      r_pend  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= w_first;
            r_err   <= w_first_err;
            if (req_li && w_li_two) begin
              r_pend  <= w_li_second;
              r_state <= S_LI2;
            end
          end else if (inst_ready) begin
            r_valid <= 1'b0;
          end
        end
        S_LI2: begin
          // word 1 is always valid here; swap in word 2 as it drains
          if (r_valid && inst_ready) begin
            r_out   <= r_pend;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: dut_a uses default parameters,
// dut_b uses LI_ELIDE=0 and SUPPORT_F=0.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_li;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;

  logic        a_req_valid, a_req_ready, a_inst_valid, a_inst_ready, a_inst_err;
  logic [31:0] a_inst_out;
  logic        b_req_valid, b_req_ready, b_inst_valid, b_inst_ready, b_inst_err;
  logic [31:0] b_inst_out;

  typedef struct packed {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  inst_encoder #(.SUPPORT_F(1), .LI_ELIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_li(req_li),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(a_inst_valid), .inst_ready(a_inst_ready),
    .inst_out(a_inst_out), .inst_err(a_inst_err)
  );

  inst_encoder #(.SUPPORT_F(0), .LI_ELIDE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_li(req_li),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready),
    .inst_out(b_inst_out), .inst_err(b_inst_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // monitors: pop the expected word whenever a word is handed over
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && a_inst_valid && a_inst_ready) begin
      if (qa.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected: got word %h, want none", a_inst_out);
      end else begin
        e = qa.pop_front();
        chk("a_word", a_inst_out, e.w);
        chk("a_err", {31'd0, a_inst_err}, {31'd0, e.e});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_inst_valid && b_inst_ready) begin
      if (qb.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected: got word %h, want none", b_inst_out);
      end else begin
        e = qb.pop_front();
        chk("b_word", b_inst_out, e.w);
        chk("b_err", {31'd0, b_inst_err}, {31'd0, e.e});
      end
    end
  end

  // Present one request; push nexp expected words at acceptance. Returns at
  // 1 time unit after the accepting edge.
  task automatic send(input bit sel, input logic li, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input int nexp, input logic [31:0] w0, input logic e0,
                      input logic [31:0] w1);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    req_li = li; req_opcode = op; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (sel ? b_req_ready : a_req_ready) ok = 1;
      else n++;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: got no req_ready in %0d cycles, want acceptance", n);
    end else begin
      if (nexp >= 1) begin
        if (sel) qb.push_back('{w: w0, e: e0}); else qa.push_back('{w: w0, e: e0});
      end
      if (nexp >= 2) begin
        if (sel) qb.push_back('{w: w1, e: 1'b0}); else qa.push_back('{w: w1, e: 1'b0});
      end
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic enc(input bit sel, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] w, input logic e);
    send(sel, 1'b0, op, f3, f7, rd, rs1, rs2, imm, 1, w, e, 32'd0);
  endtask

  task automatic li(input bit sel, input logic [4:0] rd, input logic [31:0] imm,
                    input int nexp, input logic [31:0] w0, input logic [31:0] w1);
    send(sel, 1'b1, 7'h00, 3'd0, 7'd0, rd, 5'd0, 5'd0, imm, nexp, w0, 1'b0, w1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    a_inst_ready = 1'b1; b_inst_ready = 1'b1;
    req_li = 1'b0; req_opcode = 7'd0; req_funct3 = 3'd0; req_funct7 = 7'd0;
    req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, a_inst_valid}, 32'd0);
    chk("rst_out", a_inst_out, 32'd0);
    chk("rst_err", {31'd0, a_inst_err}, 32'd0);
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, a_req_ready}, 32'd1);
    @(posedge clk); #1;

    // ADDI x1,x2,-1 with one-cycle latency
    enc(0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    @(negedge clk);
    chk("addi_lat_valid", {31'd0, a_inst_valid}, 32'd1);
    chk("addi_lat_out", a_inst_out, 32'hFFF1_0093);
    @(posedge clk); #1;

    // branches: legal, odd, too far, most negative
    enc(0, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_8463, 1'b0);
    enc(0, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7,          32'h0020_8363, 1'b1);
    enc(0, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096,       32'h8020_8063, 1'b1);
    enc(0, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 32'h8020_8063, 1'b0);
    // R-type ADD/SUB, FADD.S
    enc(0, 7'b0110011, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    enc(0, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    enc(0, 7'b1010011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00D3, 1'b0);
    // SW x2,-4(x1); FLW f1,8(x2)
    enc(0, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
    enc(0, 7'b0000111, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8,          32'h0081_2087, 1'b0);
    // I-type range edges
    enc(0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF0_0093, 1'b0);
    enc(0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b1);
    // JAL
    enc(0, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h0010_00EF, 1'b0);
    enc(0, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h8000_00EF, 1'b1);
    // LUI
    enc(0, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    enc(0, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
    // illegal opcodes
    enc(0, 7'h7F, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd5, 32'h0000_0013, 1'b1);
    enc(0, 7'h31, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0000_0013, 1'b1);

    // LI with elision
    li(0, 5'd5, 32'h0000_0123, 1, 32'h1230_0293, 32'd0);
    li(0, 5'd5, 32'h1234_5000, 1, 32'h1234_52B7, 32'd0);
    li(0, 5'd5, 32'h0000_0000, 1, 32'h0000_0293, 32'd0);
    li(0, 5'd5, 32'hFFFF_FFFF, 1, 32'hFFF0_0293, 32'd0);
    li(0, 5'd5, 32'hFFFF_F800, 1, 32'h8000_0293, 32'd0);
    li(0, 5'd5, 32'h1234_5FFF, 2, 32'h1234_62B7, 32'hFFF2_8293);
    @(negedge clk);
    chk("li2_req_ready", {31'd0, a_req_ready}, 32'd0);
    @(posedge clk); #1;

    // backpressure during a two-word LI
    repeat (3) @(posedge clk); #1;
    a_inst_ready = 1'b0;
    li(0, 5'd5, 32'h1234_5FFF, 2, 32'h1234_62B7, 32'hFFF2_8293);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, a_inst_valid}, 32'd1);
      chk("bp_word1", a_inst_out, 32'h1234_62B7);
      chk("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    a_inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_word2_valid", {31'd0, a_inst_valid}, 32'd1);
    chk("bp_word2", a_inst_out, 32'hFFF2_8293);
    @(posedge clk); #1;

    // reset while the second LI word is pending
    repeat (2) @(posedge clk); #1;
    a_inst_ready = 1'b0;
    li(0, 5'd5, 32'h1234_5FFF, 0, 32'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("li2rst_req_ready", {31'd0, a_req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_inst_ready = 1'b1;
    @(negedge clk);
    chk("li2rst_valid", {31'd0, a_inst_valid}, 32'd0);
    chk("li2rst_idle", {31'd0, a_req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("li2rst_no_word2", {31'd0, a_inst_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // dut_b: LI_ELIDE=0, SUPPORT_F=0
    li(1, 5'd5, 32'h0000_0123, 2, 32'h0000_02B7, 32'h1232_8293);
    li(1, 5'd5, 32'h1234_5000, 2, 32'h1234_52B7, 32'h0002_8293);
    enc(1, 7'b0000111, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h0000_0013, 1'b1);
    enc(1, 7'b1010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0000_0013, 1'b1);
    enc(1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
